// File: rtl/hazard_if.sv
// Pipeline <-> hazard controller bundle: register addresses and pipeline status in,
// stall/flush/forward controls and performance counters out.
interface hazard_if #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 32
);
   logic [REG_ADDR_W-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic                  mem_read_e, reg_write_m, reg_write_w, pc_src_e;
   logic                  dmem_req_m, dmem_ready;
   logic                  stall_fetch, stall_decode, stall_execute, stall_memory;
   logic                  flush_decode, flush_execute;
   logic [1:0]            fwd_a_e, fwd_b_e;
   logic                  mem_timeout;
   logic [CNT_W-1:0]      stall_cycles, flush_count;

   modport master (
      output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
      output mem_read_e, reg_write_m, reg_write_w, pc_src_e, dmem_req_m, dmem_ready,
      input  stall_fetch, stall_decode, stall_execute, stall_memory,
      input  flush_decode, flush_execute, fwd_a_e, fwd_b_e,
      input  mem_timeout, stall_cycles, flush_count
   );

   modport slave (
      input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
      input  mem_read_e, reg_write_m, reg_write_w, pc_src_e, dmem_req_m, dmem_ready,
      output stall_fetch, stall_decode, stall_execute, stall_memory,
      output flush_decode, flush_execute, fwd_a_e, fwd_b_e,
      output mem_timeout, stall_cycles, flush_count
   );
endinterface

// File: rtl/hazard_controller.sv
// Stall/flush/forwarding control for the 5-stage core, with a timed data-memory
// wait FSM and saturating stall/flush performance counters.
module hazard_controller #(
   parameter int REG_ADDR_W  = 5,
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic     clk,
   input  logic     reset,
   hazard_if.slave  hz
);
   localparam int WCW = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic {RUN, MEM_WAIT} state_t;

   state_t           state, cur;
   logic [WCW-1:0]   wcnt;
   logic             mto;
   logic [CNT_W-1:0] sc, fc;
   logic             wait_to, mem_stall, branch, load_use;

   // Reset forces RUN decode even before the state register has been cleared.
   assign cur       = reset ? RUN : state;
   assign wait_to   = (cur == MEM_WAIT) && (wcnt == WCW'(MEM_TIMEOUT));
   assign mem_stall = (cur == RUN) ? (hz.dmem_req_m && !hz.dmem_ready)
                                   : (!hz.dmem_ready && !wait_to);
   assign branch    = !mem_stall && hz.pc_src_e;
   assign load_use  = !mem_stall && !hz.pc_src_e && hz.mem_read_e && (hz.rd_e != '0) &&
                      ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));

   assign hz.stall_fetch   = mem_stall || load_use;
   assign hz.stall_decode  = mem_stall || load_use;
   assign hz.stall_execute = mem_stall;
   assign hz.stall_memory  = mem_stall;
   assign hz.flush_decode  = branch;
   assign hz.flush_execute = branch || load_use;
   assign hz.mem_timeout   = mto;
   assign hz.stall_cycles  = sc;
   assign hz.flush_count   = fc;

   logic [1:0][REG_ADDR_W-1:0] rs_e;
   logic [1:0][1:0]            fwd;
   assign rs_e = {hz.rs2_e, hz.rs1_e};

   // Memory stage wins over Writeback: it holds the younger result.
   for (genvar i = 0; i < 2; i++) begin : g_fwd
      always_comb begin
         fwd[i] = 2'b00;
         if (hz.reg_write_m && (hz.rd_m != '0) && (hz.rd_m == rs_e[i]))
            fwd[i] = 2'b10;
         else if (hz.reg_write_w && (hz.rd_w != '0) && (hz.rd_w == rs_e[i]))
            fwd[i] = 2'b01;
      end
   end
   assign hz.fwd_a_e = fwd[0];
   assign hz.fwd_b_e = fwd[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
         wcnt  <= '0;
         mto   <= 1'b0;
         sc    <= '0;
         fc    <= '0;
      end else begin
         case (state)
            RUN:
               if (hz.dmem_req_m && !hz.dmem_ready) begin
                  state <= MEM_WAIT;
                  wcnt  <= WCW'(1);
               end
            MEM_WAIT:
               if (hz.dmem_ready) begin
                  state <= RUN;
                  wcnt  <= '0;
               end else if (wait_to) begin
                  state <= RUN;
                  wcnt  <= '0;
                  mto   <= 1'b1;
               end else begin
                  wcnt  <= wcnt + WCW'(1);
               end
            default: state <= RUN;
         endcase
         if (hz.stall_fetch && (sc != '1)) sc <= sc + CNT_W'(1);
         if (branch && (fc != '1))         fc <= fc + CNT_W'(1);
      end
   end
endmodule

// File: doc/hazard_controller.md
# hazard_controller

Central hazard controller for the five-stage pipelined RISC-V core. It generates the stall and flush controls for the Fetch/Decode and Decode/Execute pipeline registers, plus the Execute-stage operand forwarding selects. It sequences multi-cycle data-memory waits through a small FSM with a timeout. It also keeps saturating stall and flush performance counters.

## Interface
- REG_ADDR_W, 5, register-file address width
- CNT_W, 32, width of performance counters
- MEM_TIMEOUT, 64, max cycles in memory wait before forced release
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- rs1_d, rs2_d  in  REG_ADDR_W  source registers of instruction in Decode
- rs1_e, rs2_e  in  REG_ADDR_W  source registers of instruction in Execute
- rd_e  in  REG_ADDR_W  destination in Execute; mem_read_e in 1: Execute instruction is a load
- rd_m, rd_w  in  REG_ADDR_W  destinations in Memory / Writeback
- reg_write_m, reg_write_w  in  1  Memory / Writeback instruction writes rd
- pc_src_e  in  1  taken branch or jump resolved in Execute
- dmem_req_m  in  1  Memory stage issues a data-memory access; dmem_ready in 1: access completes this cycle
- stall_fetch, stall_decode, stall_execute, stall_memory  out  1  hold the PC and the corresponding pipeline register
- flush_decode, flush_execute  out  1  load a bubble (all zeros) into Fetch/Decode resp. Decode/Execute register
- fwd_a_e, fwd_b_e  out  2  operand select: 00 register file, 10 from Memory, 01 from Writeback
- mem_timeout  out  1  sticky error flag
- stall_cycles, flush_count  out  CNT_W  performance counters

## Operation
- FSM states: RUN, MEM_WAIT. Reset → RUN.
- Priority: memory wait > branch flush > load-use stall.
- RUN + dmem_req_m & !dmem_ready:
  - all four stalls = 1; no flushes.
  - Next state MEM_WAIT; wait counter ← 1.
- RUN + dmem_req_m & dmem_ready: no stall.
- MEM_WAIT + !dmem_ready: all stalls = 1; wait counter increments.
- MEM_WAIT + dmem_ready: stalls = 0 this cycle; → RUN.
- MEM_WAIT + wait counter == MEM_TIMEOUT:
  - stalls = 0; mem_timeout ← 1, held until reset.
  - → RUN.
- Branch, when not memory-stalled and pc_src_e=1:
  - flush_decode=1, flush_execute=1; no stalls.
  - flush_count increments.
  - A simultaneous load-use hazard is ignored, because the Decode instruction is squashed.
- Load-use, when not memory-stalled and no branch:
  - Condition: mem_read_e & rd_e≠0 & (rd_e==rs1_d | rd_e==rs2_d).
  - Outputs: stall_fetch=1, stall_decode=1, flush_execute=1.
- Forwarding, per operand (rs1_e→fwd_a_e, rs2_e→fwd_b_e):
  - 10 if reg_write_m & rd_m≠0 & rd_m==rs.
  - Else 01 if reg_write_w & rd_w≠0 & rd_w==rs.
  - Else 00.
  - Memory has priority over Writeback.
  - Forwarding is valid in all states.
- stall_cycles increments on every cycle with stall_fetch=1.
- Both counters saturate at all-ones.

## Timing
- All stall/flush/fwd outputs are combinational from the current inputs and the registered state. Pipeline registers act on them at their next update edge.
- State, wait counter, mem_timeout and perf counters are registered on rising clk.
- Reset values: state RUN, wait counter 0, mem_timeout 0, stall_cycles 0, flush_count 0.
- With all inputs 0 after reset, every output is 0.
- reset=1 mid-MEM_WAIT: the next edge returns the state to RUN and clears all counters and the flag. While reset=1, outputs follow RUN-state decode.
- Load-use costs exactly one bubble: the hazard clears once the load moves to Memory.
- A taken branch costs two squashed instructions.

## Test plan
- Load-use: load x5 in Execute (rd_e=5, mem_read_e=1), rs1_d=5 → stall_fetch=stall_decode=flush_execute=1 for one cycle, stall_cycles=1.
- Load-use with rd_e=0, rs1_d=0 → no stall or flush.
- Branch + load-use in the same cycle (pc_src_e=1, hazard present) → flush_decode=flush_execute=1, no stalls, flush_count=1.
- Forwarding: rd_m=rd_w=3, both reg_write=1, rs1_e=3 → fwd_a_e=10. With reg_write_m=0 → fwd_a_e=01.
- Memory wait: dmem_req_m=1, dmem_ready=0 for 3 cycles, then ready → all stalls high exactly 3 cycles, low on the ready cycle, state RUN after, stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, ready never asserted → stalls drop after the 4th wait cycle, mem_timeout=1 and stays set. reset=1 for one cycle clears it and both counters.
